fifo_south: RTL and testbench

FIFO_SOUTH -- requirements
Module: fifo_south

---
 rtl/fifo_south_pkg.sv | 5 +
 rtl/fifo_fwft.sv | 44 ++++
 rtl/fifo_south.sv | 95 +++++++++
 tb/tb_fifo_south.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fifo_south_pkg.sv
// fifo_south_pkg: shared drain FSM encoding and row counter width
package fifo_south_pkg;
  typedef enum logic {IDLE, EMIT} state_e;
  localparam int ROW_CNT_W = 16;
endpackage

// File: rtl/fifo_fwft.sv
// fifo_fwft: first-word-fall-through FIFO with occupancy-derived full/empty flags
module fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic push, pop;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == (ADDR_WIDTH+1)'(DEPTH);
    pop = re && !empty;
    push = we && (!full || pop);
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(pop);
    cnt_d = cnt_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
  end
  assign data_out = mem_q[rd_ptr_q];
  assign count = cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= data_in;
endmodule

// File: rtl/fifo_south.sv
// fifo_south: buffers per-column results and serializes complete rows onto one output stream
module fifo_south
  import fifo_south_pkg::*;
#(
  parameter int COL = 3,
  parameter int W_DATA = 8,
  parameter int W_ADDR = 8,
  localparam int W_COL = COL > 1 ? $clog2(COL) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [COL*W_DATA-1:0] i_data,
  input  logic [COL-1:0]       i_valid,
  output logic [W_DATA-1:0]    o_data,
  output logic [W_COL-1:0]     o_col,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [COL-1:0]       o_fifo_empty,
  output logic [COL-1:0]       o_fifo_full,
  output logic [COL-1:0]       o_overflow,
  output logic [ROW_CNT_W-1:0] o_row_count
);
  state_e state_q, state_d;
  logic [W_COL-1:0] k_q, k_d, col_q, col_d;
  logic [W_DATA-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic [ROW_CNT_W-1:0] row_q, row_d;
  logic [COL-1:0] ovf_q, ovf_d, pop, push_ok, nonempty_nxt;
  logic [W_DATA-1:0] head [COL];
  logic [W_ADDR:0] cnt [COL];
  logic load, last;
  for (genvar i = 0; i < COL; i++) begin : g_col
    fifo_fwft #(.DATA_WIDTH(W_DATA), .ADDR_WIDTH(W_ADDR)) u_fifo (
      .clk(i_clk),
      .rst_n(i_rst_n),
      .data_in(i_data[W_DATA*(COL-i)-1 -: W_DATA]),
      .we(i_valid[i]),
      .re(pop[i]),
      .data_out(head[i]),
      .empty(o_fifo_empty[i]),
      .full(o_fifo_full[i]),
      .count(cnt[i])
    );
    assign pop[i] = load && k_q == W_COL'(i);
    assign push_ok[i] = i_valid[i] && (!o_fifo_full[i] || pop[i]);
    // occupancy after this edge is nonzero unless push and pop exactly cancel the current count
    assign nonempty_nxt[i] = cnt[i] + (W_ADDR+1)'(push_ok[i]) != (W_ADDR+1)'(pop[i]);
  end
  always_comb begin
    load = state_q == EMIT && (!valid_q || i_ready);
    last = k_q == W_COL'(COL-1);
    state_d = state_q;
    k_d = k_q;
    row_d = row_q;
    valid_d = load || (valid_q && !i_ready);
    data_d = load ? head[k_q] : data_q;
    col_d = load ? k_q : col_q;
    ovf_d = ovf_q | (i_valid & o_fifo_full & ~pop);
    if (state_q == IDLE) begin
      if (!(|o_fifo_empty)) begin
        state_d = EMIT;
        k_d = '0;
      end
    end else if (load) begin
      k_d = last ? '0 : k_q + 1'b1;
      if (last) begin
        row_d = row_q + 1'b1;
        state_d = &nonempty_nxt ? EMIT : IDLE;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      col_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      row_q <= '0;
      ovf_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      col_q <= col_d;
      data_q <= data_d;
      valid_q <= valid_d;
      row_q <= row_d;
      ovf_q <= ovf_d;
    end
  assign o_data = data_q;
  assign o_col = col_q;
  assign o_valid = valid_q;
  assign o_row_count = row_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_fifo_south.sv
// tb_fifo_south: directed scoreboard bench for the south drain FIFO
module tb_fifo_south;
  logic clk = 0, rst_n = 0, i_ready = 1;
  logic [23:0] i_data = '0;
  logic [2:0] i_valid = '0;
  logic [7:0] o_data;
  logic [1:0] o_col;
  logic o_valid;
  logic [2:0] o_fifo_empty, o_fifo_full, o_overflow;
  logic [15:0] o_row_count;
  int checks = 0, errors = 0;
  logic [9:0] exp_q [$];
  fifo_south #(.COL(3), .W_DATA(8), .W_ADDR(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_data(o_data), .o_col(o_col), .o_valid(o_valid), .i_ready(i_ready),
    .o_fifo_empty(o_fifo_empty), .o_fifo_full(o_fifo_full),
    .o_overflow(o_overflow), .o_row_count(o_row_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(logic [23:0] d, logic [2:0] v);
    i_data = d;
    i_valid = v;
    step();
    i_valid = '0;
  endtask
  task automatic expect_row(logic [23:0] d, int n);
    for (int c = 0; c < n; c++) exp_q.push_back({2'(c), d[23-8*c -: 8]});
  endtask
  task automatic reset_pulse();
    rst_n = 0;
    step();
    rst_n = 1;
    step();
  endtask
  always @(negedge clk)
    if (rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected", {22'd0, o_col, o_data}, 32'hFFFF_FFFF);
      else chk("sb_word", {22'd0, o_col, o_data}, {22'd0, exp_q.pop_front()});
    end
  initial begin
    step(2);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_row", o_row_count, 0);
    chk("rst_empty", o_fifo_empty, 3'b111);
    chk("rst_full", o_fifo_full, 0);
    rst_n = 1;
    step();
    expect_row(24'h112233, 3);
    push(24'h112233, 3'b111);
    chk("t1_lat0", o_valid, 0);
    step();
    chk("t1_lat1", o_valid, 0);
    step();
    chk("t1_w0", {o_valid, o_col, o_data}, {1'b1, 2'd0, 8'h11});
    step();
    chk("t1_w1", {o_valid, o_col, o_data}, {1'b1, 2'd1, 8'h22});
    step();
    chk("t1_w2", {o_valid, o_col, o_data}, {1'b1, 2'd2, 8'h33});
    chk("t1_rows", o_row_count, 1);
    step();
    chk("t1_idle", o_valid, 0);
    chk("t1_empty", o_fifo_empty, 3'b111);
    push(24'hAABB00, 3'b011);
    step(3);
    chk("t2_partial_valid", o_valid, 0);
    chk("t2_partial_empty", o_fifo_empty, 3'b100);
    expect_row(24'hAABBCC, 3);
    push(24'h0000CC, 3'b100);
    step(2);
    chk("t2_w0", {o_valid, o_col, o_data}, {1'b1, 2'd0, 8'hAA});
    step(2);
    chk("t2_w2", {o_valid, o_col, o_data}, {1'b1, 2'd2, 8'hCC});
    chk("t2_rows", o_row_count, 2);
    step();
    expect_row(24'h112233, 3);
    push(24'h112233, 3'b111);
    step(3);
    chk("t3_w1", {o_valid, o_col, o_data}, {1'b1, 2'd1, 8'h22});
    i_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold", {o_valid, o_col, o_data}, {1'b1, 2'd1, 8'h22});
    end
    i_ready = 1;
    step();
    chk("t3_release", {o_valid, o_col, o_data}, {1'b1, 2'd2, 8'h33});
    chk("t3_rows", o_row_count, 3);
    step();
    chk("t3_idle", o_valid, 0);
    for (int i = 1; i <= 4; i++) push({8'h00, 8'(8'hA0 + i), 8'h00}, 3'b010);
    chk("t4_full", o_fifo_full, 3'b010);
    chk("t4_no_ovf", o_overflow, 0);
    push(24'h00A500, 3'b010);
    chk("t4_ovf", o_overflow, 3'b010);
    chk("t4_still_full", o_fifo_full, 3'b010);
    chk("t4_no_emit", o_valid, 0);
    reset_pulse();
    chk("t4_ovf_cleared", o_overflow, 0);
    expect_row(24'h123456, 2);
    push(24'h123456, 3'b111);
    step(2);
    chk("t5_w0", {o_valid, o_col, o_data}, {1'b1, 2'd0, 8'h12});
    step();
    chk("t5_w1", {o_valid, o_col, o_data}, {1'b1, 2'd1, 8'h34});
    step();
    rst_n = 0;
    #1;
    chk("t5_async_valid", o_valid, 0);
    chk("t5_async_data", {o_col, o_data}, 0);
    chk("t5_async_row", o_row_count, 0);
    chk("t5_async_empty", o_fifo_empty, 3'b111);
    step();
    rst_n = 1;
    step();
    expect_row(24'h778899, 3);
    push(24'h778899, 3'b111);
    step(2);
    chk("t5_first_after_rst", {o_valid, o_col, o_data}, {1'b1, 2'd0, 8'h77});
    step(2);
    chk("t5_rows", o_row_count, 1);
    step();
    reset_pulse();
    i_ready = 0;
    expect_row(24'h010203, 3);
    expect_row(24'h040506, 3);
    expect_row(24'h070809, 3);
    push(24'h010203, 3'b111);
    push(24'h040506, 3'b111);
    push(24'h070809, 3'b111);
    step(3);
    i_ready = 1;
    for (int i = 0; i < 9; i++) begin
      chk("t6_stream", {o_valid, o_col, o_data}, {1'b1, 2'(i % 3), 8'(i + 1)});
      step();
    end
    chk("t6_idle", o_valid, 0);
    chk("t6_rows", o_row_count, 3);
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
